msx_rom_detect: RTL

// - Streams cartridge ROM bytes during the HPS download and infers the mapper type and battery-SRAM size.
// - Sits between the ioctl download path and msx_config; drives mapper_detected[n] and sram_size_detected[n].
// - Instanced once per cartridge slot (A, B).
// - Detection is heuristic: it scores Z80 stores into known bank-register addresses.

---
 rtl/msx_rom_detect_pkg.sv | 67 ++++++
 rtl/msx_rom_store_parser.sv | 72 +++++++
 rtl/msx_rom_detect.sv | 107 ++++++++++
 3 files changed

// File: rtl/msx_rom_detect_pkg.sv
// Shared encodings for MSX cartridge mapper detection: mapper codes, SRAM sizes,
// score indices and the store-address classifier.
package msx_rom_detect_pkg;

    localparam logic [5:0] MAPPER_NO_UNKNOWN = 6'd0;
    localparam logic [5:0] MAPPER_LINEAR64   = 6'd1;
    localparam logic [5:0] MAPPER_KONAMI     = 6'd2;
    localparam logic [5:0] MAPPER_KONAMISCC  = 6'd3;
    localparam logic [5:0] MAPPER_ASCII8     = 6'd4;
    localparam logic [5:0] MAPPER_ASCII16    = 6'd5;

    localparam logic [2:0] SRAM_NONE = 3'd0;
    localparam logic [2:0] SRAM_1K   = 3'd1;
    localparam logic [2:0] SRAM_2K   = 3'd2;
    localparam logic [2:0] SRAM_4K   = 3'd3;
    localparam logic [2:0] SRAM_8K   = 3'd4;
    localparam logic [2:0] SRAM_16K  = 3'd5;
    localparam logic [2:0] SRAM_32K  = 3'd6;

    localparam logic [7:0]  OP_LD_NN_A       = 8'h32;
    localparam logic [7:0]  OP_LD_A_N        = 8'h3E;
    localparam logic [24:0] LINEAR_MAX_BYTES = 25'd65536;
    localparam int          NUM_SCORES       = 4;

    typedef enum logic [1:0] {
        SCORE_KONAMI,
        SCORE_KONAMISCC,
        SCORE_ASCII8,
        SCORE_ASCII16
    } mapper_score_t;

    typedef enum logic [1:0] {
        PS_IDLE,
        PS_LDA,
        PS_ST_LO,
        PS_ST_HI
    } parse_state_t;

    // Tie-break order: earlier entries win when scores are equal.
    localparam mapper_score_t SCORE_PRIO [NUM_SCORES] =
        '{SCORE_KONAMISCC, SCORE_KONAMI, SCORE_ASCII16, SCORE_ASCII8};

    function automatic logic [NUM_SCORES-1:0] classify_addr(input logic [15:0] addr);
        logic [NUM_SCORES-1:0] hits;
        hits = '0;
        hits[SCORE_KONAMI]    = (addr == 16'h4000) || (addr == 16'h6000) ||
                                (addr == 16'h8000) || (addr == 16'hA000);
        hits[SCORE_KONAMISCC] = (addr == 16'h5000) || (addr == 16'h7000) ||
                                (addr == 16'h9000) || (addr == 16'hB000);
        hits[SCORE_ASCII8]    = (addr == 16'h6000) || (addr == 16'h6800) ||
                                (addr == 16'h7000) || (addr == 16'h7800);
        hits[SCORE_ASCII16]   = (addr == 16'h6000) || (addr == 16'h7000) ||
                                (addr == 16'h77FF);
        return hits;
    endfunction

    function automatic logic [5:0] mapper_code(input mapper_score_t sel);
        case (sel)
            SCORE_KONAMI:    return MAPPER_KONAMI;
            SCORE_KONAMISCC: return MAPPER_KONAMISCC;
            SCORE_ASCII8:    return MAPPER_ASCII8;
            SCORE_ASCII16:   return MAPPER_ASCII16;
            default:         return MAPPER_NO_UNKNOWN;
        endcase
    endfunction

endpackage

// File: rtl/msx_rom_store_parser.sv
// Tracks Z80 "LD A,n" and "LD (nn),A" in the downloaded byte stream and reports
// each completed store address together with the last loaded immediate.
module msx_rom_store_parser
    import msx_rom_detect_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        wr,
    input  logic [7:0]  data,
    output logic        st_vld,
    output logic [15:0] st_addr,
    output logic        imm_vld,
    output logic [7:0]  imm
);

    parse_state_t state, state_next;
    logic [7:0]   lo, lo_next, imm_next;
    logic         imm_vld_next;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state   <= PS_IDLE;
            lo      <= '0;
            imm     <= '0;
            imm_vld <= 1'b0;
        end else begin
            state   <= state_next;
            lo      <= lo_next;
            imm     <= imm_next;
            imm_vld <= imm_vld_next;
        end
    end

    // Operand bytes are never re-examined as opcodes, so no re-sync on 0x32.
    always_comb begin
        state_next   = state;
        lo_next      = lo;
        imm_next     = imm;
        imm_vld_next = imm_vld;
        st_vld       = 1'b0;
        st_addr      = {data, lo};
        if (wr) begin
            case (state)
                PS_IDLE: begin
                    if (data == OP_LD_NN_A) begin
                        state_next = PS_ST_LO;
                    end else begin
                        imm_vld_next = 1'b0;
                        if (data == OP_LD_A_N) state_next = PS_LDA;
                    end
                end
                PS_LDA: begin
                    imm_next     = data;
                    imm_vld_next = 1'b1;
                    state_next   = PS_IDLE;
                end
                PS_ST_LO: begin
                    lo_next    = data;
                    state_next = PS_ST_HI;
                end
                PS_ST_HI: begin
                    st_vld       = 1'b1;
                    imm_vld_next = 1'b0;
                    state_next   = PS_IDLE;
                end
                default: state_next = PS_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/msx_rom_detect.sv
// Scores bank-register stores seen during a cartridge download and registers a
// mapper / SRAM-size verdict one clock after rom_done.
module msx_rom_detect
    import msx_rom_detect_pkg::*;
#(
    parameter int HIT_MIN = 2,
    parameter int SCORE_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rom_start,
    input  logic       rom_wr,
    input  logic [7:0] rom_data,
    input  logic       rom_done,
    output logic [5:0] mapper_detected,
    output logic [2:0] sram_size_detected,
    output logic       detect_valid
);

    localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;
    localparam logic [SCORE_W-1:0] HIT_THRESH = SCORE_W'(HIT_MIN);
    localparam logic [24:0]        CNT_MAX    = '1;

    logic                  byte_wr;
    logic                  st_vld, imm_vld;
    logic [15:0]           st_addr;
    logic [7:0]            imm;
    logic [NUM_SCORES-1:0] hits;
    logic [SCORE_W-1:0]    score [NUM_SCORES];
    logic [SCORE_W-1:0]    score_next [NUM_SCORES];
    logic [24:0]           byte_cnt, byte_cnt_next;
    logic                  sram_hit, sram_hit_next;
    logic                  found;
    logic [SCORE_W-1:0]    best;
    mapper_score_t         win_sel;
    logic [5:0]            mapper_verdict;
    logic [2:0]            sram_verdict;

    // A byte arriving with rom_start belongs to no download and is dropped.
    assign byte_wr = rom_wr && !rom_start;

    msx_rom_store_parser u_parser (
        .clk     (clk),
        .reset   (reset),
        .clear   (rom_start || rom_done),
        .wr      (byte_wr),
        .data    (rom_data),
        .st_vld  (st_vld),
        .st_addr (st_addr),
        .imm_vld (imm_vld),
        .imm     (imm)
    );

    always_comb begin
        hits = st_vld ? classify_addr(st_addr) : '0;
        for (int i = 0; i < NUM_SCORES; i++) begin
            score_next[i] = (hits[i] && score[i] != SCORE_MAX) ? score[i] + 1'b1 : score[i];
        end
        byte_cnt_next = (byte_wr && byte_cnt != CNT_MAX) ? byte_cnt + 25'd1 : byte_cnt;
        sram_hit_next = sram_hit ||
                        (imm_vld && imm[7] && (hits[SCORE_ASCII8] || hits[SCORE_ASCII16]));
    end

    // Verdict uses next-state values so a byte coinciding with rom_done counts.
    always_comb begin
        found   = 1'b0;
        best    = '0;
        win_sel = SCORE_KONAMI;
        for (int k = 0; k < NUM_SCORES; k++) begin
            if (score_next[SCORE_PRIO[k]] >= HIT_THRESH &&
                (!found || score_next[SCORE_PRIO[k]] > best)) begin
                found   = 1'b1;
                best    = score_next[SCORE_PRIO[k]];
                win_sel = SCORE_PRIO[k];
            end
        end
        sram_verdict = SRAM_NONE;
        if (!found) begin
            mapper_verdict = (byte_cnt_next <= LINEAR_MAX_BYTES) ? MAPPER_LINEAR64 : MAPPER_NO_UNKNOWN;
        end else begin
            mapper_verdict = mapper_code(win_sel);
            if (sram_hit_next && win_sel == SCORE_ASCII8)  sram_verdict = SRAM_8K;
            if (sram_hit_next && win_sel == SCORE_ASCII16) sram_verdict = SRAM_2K;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || rom_start) begin
            for (int i = 0; i < NUM_SCORES; i++) score[i] <= '0;
            byte_cnt           <= '0;
            sram_hit           <= 1'b0;
            mapper_detected    <= MAPPER_NO_UNKNOWN;
            sram_size_detected <= SRAM_NONE;
            detect_valid       <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_SCORES; i++) score[i] <= score_next[i];
            byte_cnt <= byte_cnt_next;
            sram_hit <= sram_hit_next;
            if (rom_done) begin
                mapper_detected    <= mapper_verdict;
                sram_size_detected <= sram_verdict;
                detect_valid       <= 1'b1;
            end
        end
    end

endmodule
